mem_write_checker: RTL and testbench

Synthesizable self-checking monitor for the pipelined processor's data-memory write port. It compares every processor store (address and data) against a loadable table of expected writes and reports pass or fail on status outputs. It replaces the bench-only "first write must be address 220, data 20" check with a parametrised, ordered, multi-entry check that has a timeout. It sits beside the core on the MemWrite/DataAdr/WriteData bus and can drive GPIO status pins in the DE0-Nano top level.

---
 rtl/mem_write_checker.sv | 150 +++++++++++++++
 tb/tb_mem_write_checker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_checker.sv
// Monitors the data-memory write port and checks every store, in order, against a loadable table
// of expected (address, data) pairs. The verdict and failure details are reported on status outputs.
module mem_write_checker #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 13,
    parameter int N_EXP   = 4,
    parameter int STRICT  = 1,
    parameter int TIMEOUT = 4096,
    localparam int IDX_W  = (N_EXP > 1) ? $clog2(N_EXP) : 1,
    localparam int MC_W   = $clog2(N_EXP + 1),
    localparam int CC_W   = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_adr,
    input  logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [MC_W-1:0]   match_count,
    output logic [ADDR_W-1:0] fail_adr,
    output logic [DATA_W-1:0] fail_data,
    output logic [CC_W-1:0]   cycle_count
);

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    state_t            state_q, state_d;
    logic [MC_W-1:0]   mc_q, mc_d;
    logic [CC_W-1:0]   cc_q, cc_d, cc_inc;
    logic [1:0]        fc_q, fc_d;
    logic [ADDR_W-1:0] fa_q, fa_d;
    logic [DATA_W-1:0] fd_q, fd_d;

    logic [ADDR_W-1:0] tbl_adr [N_EXP];
    logic [DATA_W-1:0] tbl_dat [N_EXP];
    logic [ADDR_W-1:0] exp_adr;
    logic [DATA_W-1:0] exp_dat;
    logic              adr_ok, dat_ok;

    // Expected table: frozen while a run is in progress, cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_EXP; i++) begin
                tbl_adr[i] <= '0;
                tbl_dat[i] <= '0;
            end
        end else if (cfg_we && state_q != RUN) begin
            for (int i = 0; i < N_EXP; i++) begin
                if (IDX_W'(i) == cfg_idx) begin
                    tbl_adr[i] <= cfg_addr;
                    tbl_dat[i] <= cfg_data;
                end
            end
        end
    end

    // Out-of-range indices (non power-of-two N_EXP) select nothing and read as zero.
    always_comb begin
        exp_adr = '0;
        exp_dat = '0;
        for (int i = 0; i < N_EXP; i++) begin
            if (MC_W'(i) == mc_q) begin
                exp_adr = tbl_adr[i];
                exp_dat = tbl_dat[i];
            end
        end
    end

    assign adr_ok = (data_adr == exp_adr);
    assign dat_ok = (write_data == exp_dat);
    assign cc_inc = cc_q + CC_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mc_q    <= '0;
            cc_q    <= '0;
            fc_q    <= '0;
            fa_q    <= '0;
            fd_q    <= '0;
        end else begin
            state_q <= state_d;
            mc_q    <= mc_d;
            cc_q    <= cc_d;
            fc_q    <= fc_d;
            fa_q    <= fa_d;
            fd_q    <= fd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mc_d    = mc_q;
        cc_d    = cc_q;
        fc_d    = fc_q;
        fa_d    = fa_q;
        fd_d    = fd_q;
        case (state_q)
            RUN: begin
                cc_d = cc_inc;
                if (mem_write) begin
                    if (adr_ok && dat_ok) begin
                        mc_d = mc_q + MC_W'(1);
                        if (mc_q == MC_W'(N_EXP - 1)) state_d = PASS;
                    end else if (STRICT != 0) begin
                        state_d = FAIL;
                        fc_d    = adr_ok ? 2'd2 : 2'd1;
                        fa_d    = data_adr;
                        fd_d    = write_data;
                    end
                end
                // A timeout overrides a same-edge mismatch but never a final match.
                if (cc_inc == CC_W'(TIMEOUT) && state_d != PASS) begin
                    state_d = FAIL;
                    fc_d    = 2'd3;
                    fa_d    = fa_q;
                    fd_d    = fd_q;
                end
            end
            default: begin
                if (start) begin
                    state_d = RUN;
                    mc_d    = '0;
                    cc_d    = '0;
                    fc_d    = '0;
                    fa_d    = '0;
                    fd_d    = '0;
                end
            end
        endcase
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == PASS) || (state_q == FAIL);
    assign pass        = (state_q == PASS);
    assign fail_code   = fc_q;
    assign match_count = mc_q;
    assign fail_adr    = fa_q;
    assign fail_data   = fd_q;
    assign cycle_count = cc_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: three instances (strict, non-strict, single-entry)
// share the config and store buses and are started individually.
module tb_mem_write_checker;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_s = 1'b0, start_l = 1'b0, start_o = 1'b0;
    logic        cfg_we = 1'b0;
    logic [0:0]  cfg_idx = '0;
    logic [12:0] cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic        mem_write = 1'b0;
    logic [12:0] data_adr = '0;
    logic [15:0] write_data = '0;

    logic        s_busy, s_done, s_pass;
    logic [1:0]  s_fc, s_mc;
    logic [12:0] s_fa;
    logic [15:0] s_fd;
    logic [4:0]  s_cc;

    logic        l_busy, l_done, l_pass;
    logic [1:0]  l_fc, l_mc;
    logic [12:0] l_fa;
    logic [15:0] l_fd;
    logic [4:0]  l_cc;

    logic        o_busy, o_done, o_pass;
    logic [1:0]  o_fc;
    logic [0:0]  o_mc;
    logic [12:0] o_fa;
    logic [15:0] o_fd;
    logic [4:0]  o_cc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_write_checker #(.DATA_W(16), .ADDR_W(13), .N_EXP(2), .STRICT(1), .TIMEOUT(16)) u_strict (
        .clk(clk), .reset_n(reset_n), .start(start_s), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .mem_write(mem_write), .data_adr(data_adr),
        .write_data(write_data), .busy(s_busy), .done(s_done), .pass(s_pass), .fail_code(s_fc),
        .match_count(s_mc), .fail_adr(s_fa), .fail_data(s_fd), .cycle_count(s_cc));

    mem_write_checker #(.DATA_W(16), .ADDR_W(13), .N_EXP(2), .STRICT(0), .TIMEOUT(16)) u_loose (
        .clk(clk), .reset_n(reset_n), .start(start_l), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .mem_write(mem_write), .data_adr(data_adr),
        .write_data(write_data), .busy(l_busy), .done(l_done), .pass(l_pass), .fail_code(l_fc),
        .match_count(l_mc), .fail_adr(l_fa), .fail_data(l_fd), .cycle_count(l_cc));

    mem_write_checker #(.DATA_W(16), .ADDR_W(13), .N_EXP(1), .STRICT(1), .TIMEOUT(16)) u_one (
        .clk(clk), .reset_n(reset_n), .start(start_o), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .mem_write(mem_write), .data_adr(data_adr),
        .write_data(write_data), .busy(o_busy), .done(o_done), .pass(o_pass), .fail_code(o_fc),
        .match_count(o_mc), .fail_adr(o_fa), .fail_data(o_fd), .cycle_count(o_cc));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [0:0] idx, input logic [12:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic store(input logic [12:0] a, input logic [15:0] d);
        mem_write = 1'b1; data_adr = a; write_data = d;
        tick();
        mem_write = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_busy", 32'(s_busy), 0);
        check("rst_done", 32'(s_done), 0);
        check("rst_fc", 32'(s_fc), 0);
        check("rst_mc", 32'(s_mc), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Ordered pass
        load(1'b0, 13'd220, 16'd20);
        load(1'b1, 13'd224, 16'd7);
        start_s = 1'b1; tick(); start_s = 1'b0;
        check("ord_busy", 32'(s_busy), 1);
        check("ord_cc0", 32'(s_cc), 0);
        store(13'd220, 16'd20);
        check("ord_mc1", 32'(s_mc), 1);
        check("ord_pass_early", 32'(s_pass), 0);
        store(13'd224, 16'd7);
        check("ord_pass", 32'(s_pass), 1);
        check("ord_done", 32'(s_done), 1);
        check("ord_mc2", 32'(s_mc), 2);
        check("ord_busy_off", 32'(s_busy), 0);
        check("ord_cc", 32'(s_cc), 2);

        // Data mismatch
        load(1'b0, 13'd220, 16'd20);
        start_s = 1'b1; tick(); start_s = 1'b0;
        check("dm_restart_pass", 32'(s_pass), 0);
        store(13'd220, 16'd21);
        check("dm_fc", 32'(s_fc), 2);
        check("dm_fa", 32'(s_fa), 220);
        check("dm_fd", 32'(s_fd), 21);
        check("dm_mc", 32'(s_mc), 0);
        check("dm_done", 32'(s_done), 1);
        check("dm_pass", 32'(s_pass), 0);

        // Address mismatch, then the FAIL verdict holds
        start_s = 1'b1; tick(); start_s = 1'b0;
        check("am_fc_clr", 32'(s_fc), 0);
        check("am_fa_clr", 32'(s_fa), 0);
        check("am_fd_clr", 32'(s_fd), 0);
        store(13'd221, 16'd20);
        check("am_fc", 32'(s_fc), 1);
        check("am_fa", 32'(s_fa), 221);
        check("am_fd", 32'(s_fd), 20);
        store(13'd220, 16'd20);
        check("am_hold_fc", 32'(s_fc), 1);
        check("am_hold_mc", 32'(s_mc), 0);
        check("am_hold_cc", 32'(s_cc), 1);

        // Non-strict skip
        load(1'b0, 13'd220, 16'd20);
        load(1'b1, 13'd224, 16'd7);
        start_l = 1'b1; tick(); start_l = 1'b0;
        store(13'd100, 16'd5);
        check("ns_mc0", 32'(l_mc), 0);
        check("ns_busy", 32'(l_busy), 1);
        store(13'd220, 16'd20);
        store(13'd300, 16'd9);
        check("ns_mc1", 32'(l_mc), 1);
        check("ns_fc_none", 32'(l_fc), 0);
        store(13'd224, 16'd7);
        check("ns_pass", 32'(l_pass), 1);
        check("ns_mc2", 32'(l_mc), 2);
        check("ns_cc", 32'(l_cc), 4);

        // Timeout
        start_s = 1'b1; tick(); start_s = 1'b0;
        repeat (15) tick();
        check("to_busy15", 32'(s_busy), 1);
        check("to_cc15", 32'(s_cc), 15);
        tick();
        check("to_fc", 32'(s_fc), 3);
        check("to_cc", 32'(s_cc), 16);
        check("to_busy", 32'(s_busy), 0);
        check("to_done", 32'(s_done), 1);
        check("to_fa", 32'(s_fa), 0);
        tick();
        check("to_cc_frozen", 32'(s_cc), 16);

        // Final match on the timeout edge
        load(1'b0, 13'd50, 16'd9);
        start_o = 1'b1; tick(); start_o = 1'b0;
        repeat (15) tick();
        store(13'd50, 16'd9);
        check("tie_pass", 32'(o_pass), 1);
        check("tie_fc", 32'(o_fc), 0);
        check("tie_cc", 32'(o_cc), 16);
        check("tie_mc", 32'(o_mc), 1);

        // Asynchronous reset mid-run
        load(1'b0, 13'd220, 16'd20);
        load(1'b1, 13'd224, 16'd7);
        start_s = 1'b1; tick(); start_s = 1'b0;
        store(13'd220, 16'd20);
        check("mr_mc1", 32'(s_mc), 1);
        #2 reset_n = 1'b0;
        #1;
        check("mr_busy", 32'(s_busy), 0);
        check("mr_done", 32'(s_done), 0);
        check("mr_pass", 32'(s_pass), 0);
        check("mr_fc", 32'(s_fc), 0);
        check("mr_mc", 32'(s_mc), 0);
        check("mr_cc", 32'(s_cc), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Config and start on the same edge; config writes during RUN are dropped
        cfg_we = 1'b1; cfg_idx = 1'b0; cfg_addr = 13'd220; cfg_data = 16'd20;
        start_s = 1'b1; tick(); start_s = 1'b0;
        check("cs_busy", 32'(s_busy), 1);
        cfg_idx = 1'b1; cfg_addr = 13'd224; cfg_data = 16'd7;
        store(13'd220, 16'd20);
        cfg_we = 1'b0;
        check("cs_mc1", 32'(s_mc), 1);
        store(13'd0, 16'd0);
        check("cs_clear_pass", 32'(s_pass), 1);
        check("cs_mc2", 32'(s_mc), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
